breg_ctrl: RTL and testbench

Command sequencer that drives the 4×8-bit register file (`breg`). It accepts one register-transfer command per handshake (LOAD immediate, MOV, ADD, SUB), sequences the register-file read ports, computes the result and issues the write. It is the only master of the register-file ports and sits between the command source and `breg`.

---
 rtl/breg_pkg.sv | 20 ++
 rtl/breg.sv | 34 +++
 rtl/breg_alu.sv | 40 ++++
 rtl/breg_sys.sv | 58 +++++
 rtl/breg_ctrl.sv | 106 ++++++++++
 tb/tb_breg_ctrl.sv | 213 +++++++++++++++++++++
 6 files changed

// File: rtl/breg_pkg.sv
// rtl/breg_pkg.sv - shared types and width defaults for the breg command sequencer
package breg_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 2;

    typedef enum logic [1:0] {
        OP_LOAD = 2'd0,
        OP_MOV  = 2'd1,
        OP_ADD  = 2'd2,
        OP_SUB  = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

endpackage

// File: rtl/breg.sv
// rtl/breg.sv - 4x8 register file, two combinational read ports, active-low write enable
module breg
    import breg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] add_rd0,
    input  logic [ADDR_W-1:0] add_rd1,
    output logic [DATA_W-1:0] rd0,
    output logic [DATA_W-1:0] rd1,
    input  logic [ADDR_W-1:0] add_wr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en
);

    localparam int REGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [REGS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < REGS; i++) regs_q[i] <= '0;
        end else if (!wr_en) begin
            regs_q[add_wr] <= wr_data;
        end
    end

    assign rd0 = regs_q[add_rd0];
    assign rd1 = regs_q[add_rd1];

endmodule

// File: rtl/breg_alu.sv
// rtl/breg_alu.sv - combinational result and carry/borrow for one register-transfer op
module breg_alu
    import breg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  op_t               op_i,
    input  logic [DATA_W-1:0] op0_i,
    input  logic [DATA_W-1:0] op1_i,
    input  logic [DATA_W-1:0] imm_i,
    output logic [DATA_W-1:0] result_o,
    output logic              carry_o
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    // The top bit of the widened difference is the borrow, i.e. op0 < op1.
    assign sum  = {1'b0, op0_i} + {1'b0, op1_i};
    assign diff = {1'b0, op0_i} - {1'b0, op1_i};

    always_comb begin
        result_o = imm_i;
        carry_o  = 1'b0;
        unique case (op_i)
            OP_LOAD: result_o = imm_i;
            OP_MOV:  result_o = op0_i;
            OP_ADD: begin
                result_o = sum[DATA_W-1:0];
                carry_o  = sum[DATA_W];
            end
            OP_SUB: begin
                result_o = diff[DATA_W-1:0];
                carry_o  = diff[DATA_W];
            end
            default: result_o = imm_i;
        endcase
    end

endmodule

// File: rtl/breg_sys.sv
// rtl/breg_sys.sv - sequencer wired to its register file for integration use
module breg_sys
    import breg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [ADDR_W-1:0] cmd_src0,
    input  logic [ADDR_W-1:0] cmd_src1,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic              done,
    output logic              flag_c
);

    logic [ADDR_W-1:0] add_rd0, add_rd1, add_wr;
    logic [DATA_W-1:0] rd0, rd1, wr_data;
    logic              wr_en;

    breg_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_dst   (cmd_dst),
        .cmd_src0  (cmd_src0),
        .cmd_src1  (cmd_src1),
        .cmd_imm   (cmd_imm),
        .add_rd0   (add_rd0),
        .add_rd1   (add_rd1),
        .rd0       (rd0),
        .rd1       (rd1),
        .add_wr    (add_wr),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .done      (done),
        .flag_c    (flag_c)
    );

    breg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_breg (
        .clk     (clk),
        .rst_n   (rst_n),
        .add_rd0 (add_rd0),
        .add_rd1 (add_rd1),
        .rd0     (rd0),
        .rd1     (rd1),
        .add_wr  (add_wr),
        .wr_data (wr_data),
        .wr_en   (wr_en)
    );

endmodule

// File: rtl/breg_ctrl.sv
// rtl/breg_ctrl.sv - IDLE/READ/WRITE sequencer mastering the register-file ports
module breg_ctrl
    import breg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [ADDR_W-1:0] cmd_src0,
    input  logic [ADDR_W-1:0] cmd_src1,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [ADDR_W-1:0] add_rd0,
    output logic [ADDR_W-1:0] add_rd1,
    input  logic [DATA_W-1:0] rd0,
    input  logic [DATA_W-1:0] rd1,
    output logic [ADDR_W-1:0] add_wr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_en,
    output logic              done,
    output logic              flag_c
);

    state_t            state_q, state_d;
    op_t               op_q;
    logic [ADDR_W-1:0] dst_q, src0_q, src1_q;
    logic [DATA_W-1:0] imm_q, op0_q, op1_q;
    logic              flag_q, done_q;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (cmd_valid) state_d = S_READ;
            S_READ:  state_d = S_WRITE;
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // A reset edge must never coincide with a register-file write.
    always_comb begin
        cmd_ready = (state_q == S_IDLE);
        wr_en     = !((state_q == S_WRITE) && rst_n);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q   <= OP_LOAD;
            dst_q  <= '0;
            src0_q <= '0;
            src1_q <= '0;
            imm_q  <= '0;
            op0_q  <= '0;
            op1_q  <= '0;
            flag_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == S_WRITE);
            if (state_q == S_IDLE && cmd_valid) begin
                op_q   <= op_t'(cmd_op);
                dst_q  <= cmd_dst;
                src0_q <= cmd_src0;
                src1_q <= cmd_src1;
                imm_q  <= cmd_imm;
            end
            if (state_q == S_READ) begin
                op0_q <= rd0;
                op1_q <= rd1;
            end
            if (state_q == S_WRITE && (op_q == OP_ADD || op_q == OP_SUB)) begin
                flag_q <= alu_carry;
            end
        end
    end

    breg_alu #(.DATA_W(DATA_W)) u_alu (
        .op_i     (op_q),
        .op0_i    (op0_q),
        .op1_i    (op1_q),
        .imm_i    (imm_q),
        .result_o (alu_result),
        .carry_o  (alu_carry)
    );

    assign add_rd0 = src0_q;
    assign add_rd1 = src1_q;
    assign add_wr  = dst_q;
    assign wr_data = alu_result;
    assign done    = done_q;
    assign flag_c  = flag_q;

endmodule

// File: tb/tb_breg_ctrl.sv
// tb/tb_breg_ctrl.sv - directed table-driven bench for breg_ctrl with a behavioural register file
module tb_breg_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [1:0] cmd_dst, cmd_src0, cmd_src1;
    logic [7:0] cmd_imm;
    logic [1:0] add_rd0, add_rd1, add_wr;
    logic [7:0] rd0, rd1, wr_data;
    logic       wr_en, done, flag_c;

    logic [7:0] rf [4];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign rd0 = rf[add_rd0];
    assign rd1 = rf[add_rd1];

    always @(posedge clk) begin
        if (!wr_en) rf[add_wr] <= wr_data;
    end

    breg_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_dst   (cmd_dst),
        .cmd_src0  (cmd_src0),
        .cmd_src1  (cmd_src1),
        .cmd_imm   (cmd_imm),
        .add_rd0   (add_rd0),
        .add_rd1   (add_rd1),
        .rd0       (rd0),
        .rd1       (rd1),
        .add_wr    (add_wr),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .done      (done),
        .flag_c    (flag_c)
    );

    typedef struct {
        logic [1:0] op;
        logic [1:0] dst;
        logic [1:0] s0;
        logic [1:0] s1;
        logic [7:0] imm;
        logic [7:0] exp_data;
        logic       exp_flag;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered and left on a negedge with the block idle.
    task automatic run_cmd(input int idx, input vec_t v);
        chk($sformatf("v%0d ready_idle", idx), cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = v.op;
        cmd_dst   = v.dst;
        cmd_src0  = v.s0;
        cmd_src1  = v.s1;
        cmd_imm   = v.imm;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d ready_read", idx), cmd_ready, 0);
        chk($sformatf("v%0d wr_en_read", idx), wr_en, 1);
        chk($sformatf("v%0d add_rd0", idx), add_rd0, v.s0);
        chk($sformatf("v%0d add_rd1", idx), add_rd1, v.s1);
        @(negedge clk);
        chk($sformatf("v%0d ready_write", idx), cmd_ready, 0);
        chk($sformatf("v%0d wr_en_write", idx), wr_en, 0);
        chk($sformatf("v%0d add_wr", idx), add_wr, v.dst);
        chk($sformatf("v%0d wr_data", idx), wr_data, v.exp_data);
        chk($sformatf("v%0d done_early", idx), done, 0);
        @(negedge clk);
        chk($sformatf("v%0d done", idx), done, 1);
        chk($sformatf("v%0d ready_back", idx), cmd_ready, 1);
        chk($sformatf("v%0d wr_en_after", idx), wr_en, 1);
        chk($sformatf("v%0d flag_c", idx), flag_c, v.exp_flag);
        chk($sformatf("v%0d rf", idx), rf[v.dst], v.exp_data);
    endtask

    initial begin
        vec_t v;
        int   ndone;
        int   t_done [2];
        logic drop_next;

        //            op    dst   s0    s1    imm    data   flag
        tbl[0]  = '{2'd0, 2'd2, 2'd0, 2'd0, 8'h5A, 8'h5A, 1'b0};
        tbl[1]  = '{2'd0, 2'd0, 2'd0, 2'd0, 8'hF0, 8'hF0, 1'b0};
        tbl[2]  = '{2'd0, 2'd1, 2'd0, 2'd0, 8'h20, 8'h20, 1'b0};
        tbl[3]  = '{2'd2, 2'd3, 2'd0, 2'd1, 8'h00, 8'h10, 1'b1};
        tbl[4]  = '{2'd3, 2'd3, 2'd1, 2'd0, 8'h00, 8'h30, 1'b1};
        tbl[5]  = '{2'd1, 2'd0, 2'd1, 2'd0, 8'h00, 8'h20, 1'b1};
        tbl[6]  = '{2'd0, 2'd1, 2'd0, 2'd0, 8'h80, 8'h80, 1'b1};
        tbl[7]  = '{2'd2, 2'd1, 2'd1, 2'd1, 8'h00, 8'h00, 1'b1};
        tbl[8]  = '{2'd0, 2'd2, 2'd0, 2'd0, 8'h03, 8'h03, 1'b1};
        tbl[9]  = '{2'd3, 2'd3, 2'd2, 2'd2, 8'h00, 8'h00, 1'b0};
        tbl[10] = '{2'd2, 2'd2, 2'd0, 2'd2, 8'h00, 8'h23, 1'b0};
        tbl[11] = '{2'd3, 2'd0, 2'd0, 2'd2, 8'h00, 8'hFD, 1'b1};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_dst   = 2'd0;
        cmd_src0  = 2'd0;
        cmd_src1  = 2'd0;
        cmd_imm   = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst cmd_ready", cmd_ready, 1);
        chk("rst wr_en", wr_en, 1);
        chk("rst done", done, 0);
        chk("rst flag_c", flag_c, 0);
        chk("rst add_wr", add_wr, 0);
        chk("rst wr_data", wr_data, 0);
        chk("rst add_rd0", add_rd0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle done", done, 0);

        for (int i = 0; i < 12; i++) run_cmd(i, tbl[i]);

        // Back-to-back: LOAD r1 <- 07 then ADD r2 <- r1 + r1 held valid.
        cmd_valid = 1'b1;
        cmd_op    = 2'd0;
        cmd_dst   = 2'd1;
        cmd_src0  = 2'd0;
        cmd_src1  = 2'd0;
        cmd_imm   = 8'h07;
        @(posedge clk);
        #1;
        cmd_op    = 2'd2;
        cmd_dst   = 2'd2;
        cmd_src0  = 2'd1;
        cmd_src1  = 2'd1;
        cmd_imm   = 8'h00;
        ndone     = 0;
        drop_next = 1'b0;
        t_done[0] = -1;
        t_done[1] = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (done) begin
                if (ndone < 2) t_done[ndone] = c;
                ndone++;
                if (ndone == 1) drop_next = 1'b1;
            end
            @(posedge clk);
            #1;
            if (drop_next) begin
                cmd_valid = 1'b0;
                drop_next = 1'b0;
            end
        end
        @(negedge clk);
        chk("b2b done count", ndone, 2);
        chk("b2b first done", t_done[0], 3);
        chk("b2b second done", t_done[1], 6);
        chk("b2b r1", rf[1], 8'h07);
        chk("b2b r2", rf[2], 8'h0E);
        chk("b2b flag_c", flag_c, 0);
        chk("b2b ready", cmd_ready, 1);

        // Reset during WRITE of LOAD r0 <- AA with r0 = 11.
        v = '{2'd0, 2'd0, 2'd0, 2'd0, 8'h11, 8'h11, 1'b0};
        run_cmd(12, v);
        cmd_valid = 1'b1;
        cmd_op    = 2'd0;
        cmd_dst   = 2'd0;
        cmd_imm   = 8'hAA;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid wr_en_write", wr_en, 0);
        rst_n = 1'b0;
        #1;
        chk("mid wr_en_forced", wr_en, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mid r0 kept", rf[0], 8'h11);
        chk("mid done", done, 0);
        chk("mid ready", cmd_ready, 1);
        chk("mid wr_en", wr_en, 1);
        @(negedge clk);
        chk("mid done later", done, 0);
        chk("mid r0 later", rf[0], 8'h11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
